// File: rtl/e203_dtcm_ctrl.sv
// DTCM SRAM controller: single-cycle SRAM access, in-order response path with
// a two-entry skid FIFO, and an idle-driven light-sleep power state machine.
module e203_dtcm_ctrl #(
    parameter int AW      = 14,
    parameter int DW      = 32,
    parameter int IDLE_LS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_read,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_wmask,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            dtcm_ram_cs,
    output logic            dtcm_ram_we,
    output logic [AW-1:0]   dtcm_ram_addr,
    output logic [DW/8-1:0] dtcm_ram_wem,
    output logic [DW-1:0]   dtcm_ram_din,
    input  logic [DW-1:0]   dtcm_ram_dout,
    output logic            dtcm_ram_ls,
    output logic            dtcm_ram_ds,
    output logic            dtcm_ram_sd
);

    localparam int MW = DW / 8;
    localparam logic [7:0] IDLE_MAX = 8'(IDLE_LS);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } pwr_state_e;

    pwr_state_e    state_q, state_d;
    logic [7:0]    idle_cnt_q, idle_cnt_d;
    logic          pend_q, pend_d;
    logic          pend_rd_q, pend_rd_d;
    logic [DW-1:0] fifo_mem_q [2];
    logic [DW-1:0] fifo_mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    logic          fifo_nonempty_s;
    logic [1:0]    occ_s;
    logic [DW-1:0] bypass_data_s;
    logic          push_s;
    logic          pop_s;
    logic          idle_now_s;

    // SRAM command side and response-path outputs
    always_comb begin
        fifo_nonempty_s = (count_q != 2'd0);
        // Occupancy only counts registered state, so rsp_ready never reaches cmd_ready.
        occ_s           = count_q + {1'b0, pend_q};
        cmd_ready       = ~rst & (state_q == ST_ACTIVE) & (occ_s < 2'd2);
        dtcm_ram_cs     = cmd_valid & cmd_ready;
        dtcm_ram_we     = dtcm_ram_cs & ~cmd_read;
        dtcm_ram_addr   = cmd_addr;
        dtcm_ram_din    = cmd_wdata;
        if (dtcm_ram_we) begin
            dtcm_ram_wem = cmd_wmask;
        end else begin
            dtcm_ram_wem = {MW{1'b0}};
        end
        if (pend_rd_q) begin
            bypass_data_s = dtcm_ram_dout;
        end else begin
            bypass_data_s = {DW{1'b0}};
        end
        rsp_valid = ~rst & (fifo_nonempty_s | pend_q);
        if (rst) begin
            rsp_rdata = {DW{1'b0}};
        end else if (fifo_nonempty_s) begin
            rsp_rdata = fifo_mem_q[rd_ptr_q];
        end else if (pend_q) begin
            rsp_rdata = bypass_data_s;
        end else begin
            rsp_rdata = {DW{1'b0}};
        end
        dtcm_ram_ls = ~rst & (state_q == ST_SLEEP);
        dtcm_ram_ds = 1'b0;
        dtcm_ram_sd = 1'b0;
    end

    // Pending-result capture and response FIFO bookkeeping
    always_comb begin
        pend_d     = dtcm_ram_cs;
        pend_rd_d  = dtcm_ram_cs & cmd_read;
        pop_s      = fifo_nonempty_s & rsp_ready;
        // The SRAM result lives for one cycle only; park it unless it leaves via bypass.
        push_s     = pend_q & ~(~fifo_nonempty_s & rsp_ready);
        fifo_mem_d = fifo_mem_q;
        if (push_s) begin
            fifo_mem_d[wr_ptr_q] = bypass_data_s;
        end else begin
            fifo_mem_d[wr_ptr_q] = fifo_mem_q[wr_ptr_q];
        end
        wr_ptr_d = wr_ptr_q ^ push_s;
        rd_ptr_d = rd_ptr_q ^ pop_s;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Idle counter and power-state next-state logic
    always_comb begin
        idle_now_s = ~dtcm_ram_cs & ~pend_q & ~fifo_nonempty_s;
        if ((state_q == ST_ACTIVE) && idle_now_s) begin
            if (idle_cnt_q >= IDLE_MAX) begin
                idle_cnt_d = IDLE_MAX;
            end else begin
                idle_cnt_d = idle_cnt_q + 8'd1;
            end
        end else begin
            idle_cnt_d = 8'd0;
        end
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: begin
                if (idle_now_s && (idle_cnt_d == IDLE_MAX)) begin
                    state_d = ST_SLEEP;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_SLEEP: begin
                if (cmd_valid) begin
                    state_d = ST_WAKE;
                end else begin
                    state_d = ST_SLEEP;
                end
            end
            ST_WAKE:  state_d = ST_ACTIVE;
            default:  state_d = ST_ACTIVE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ACTIVE;
            idle_cnt_q    <= 8'd0;
            pend_q        <= 1'b0;
            pend_rd_q     <= 1'b0;
            fifo_mem_q[0] <= {DW{1'b0}};
            fifo_mem_q[1] <= {DW{1'b0}};
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            pend_q        <= pend_d;
            pend_rd_q     <= pend_rd_d;
            fifo_mem_q[0] <= fifo_mem_d[0];
            fifo_mem_q[1] <= fifo_mem_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_e203_dtcm_ctrl.sv
// Scoreboard bench for e203_dtcm_ctrl with a behavioural SRAM model.
module tb_e203_dtcm_ctrl;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          dtcm_ram_cs;
    logic          dtcm_ram_we;
    logic [AW-1:0] dtcm_ram_addr;
    logic [MW-1:0] dtcm_ram_wem;
    logic [DW-1:0] dtcm_ram_din;
    logic [DW-1:0] dtcm_ram_dout;
    logic          dtcm_ram_ls;
    logic          dtcm_ram_ds;
    logic          dtcm_ram_sd;

    always #5 clk = ~clk;

    e203_dtcm_ctrl #(.AW(AW), .DW(DW), .IDLE_LS(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_read      (cmd_read),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wmask     (cmd_wmask),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .dtcm_ram_cs   (dtcm_ram_cs),
        .dtcm_ram_we   (dtcm_ram_we),
        .dtcm_ram_addr (dtcm_ram_addr),
        .dtcm_ram_wem  (dtcm_ram_wem),
        .dtcm_ram_din  (dtcm_ram_din),
        .dtcm_ram_dout (dtcm_ram_dout),
        .dtcm_ram_ls   (dtcm_ram_ls),
        .dtcm_ram_ds   (dtcm_ram_ds),
        .dtcm_ram_sd   (dtcm_ram_sd)
    );

    logic [DW-1:0] sram    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] sb [$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            n_pop = 0;
    logic          done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < MW; b++) begin
            if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        end
        return r;
    endfunction

    // SRAM model: one-cycle read latency, byte-masked writes
    always @(posedge clk) begin
        if (dtcm_ram_cs) begin
            if (dtcm_ram_we) begin
                sram[dtcm_ram_addr] <= merge(sram[dtcm_ram_addr], dtcm_ram_din, dtcm_ram_wem);
            end else begin
                dtcm_ram_dout <= sram[dtcm_ram_addr];
            end
        end
    end

    // Scoreboard: push expected result on accept, pop and compare on response handshake
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_rdata), 64'hDEAD_0000_0000_0000);
                end else begin
                    chk("rsp_data", 64'(rsp_rdata), 64'(sb.pop_front()));
                    n_pop++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_read) begin
                    sb.push_back(ref_mem[cmd_addr]);
                end else begin
                    sb.push_back({DW{1'b0}});
                    ref_mem[cmd_addr] <= merge(ref_mem[cmd_addr], cmd_wdata, cmd_wmask);
                end
                chk("outstanding_le2", 64'(sb.size() <= 2), 64'd1);
            end
        end
    end

    task automatic issue(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [MW-1:0] m);
        logic got;
        got       = 1'b0;
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wmask = m;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("issue_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n_idle;
        logic got_ls;
        logic seen;
        int   pop_base;

        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_read  = 1'b0;
        cmd_addr  = 14'd1;
        cmd_wdata = 32'h0;
        cmd_wmask = 4'hF;
        rsp_ready = 1'b1;
        done      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_cs", 64'(dtcm_ram_cs), 64'd0);
        chk("rst_we", 64'(dtcm_ram_we), 64'd0);
        chk("rst_ls", 64'(dtcm_ram_ls), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(cmd_ready), 64'd1);

        // Back-to-back write then read of the same word
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_read  = 1'b0;
        cmd_addr  = 14'd3;
        cmd_wdata = 32'hA5A5_A5A5;
        cmd_wmask = 4'hF;
        @(negedge clk);
        chk("b2b_wr_cs", 64'(dtcm_ram_cs), 64'd1);
        chk("b2b_wr_wem", 64'(dtcm_ram_wem), 64'hF);
        @(posedge clk);
        #1;
        cmd_read = 1'b1;
        @(negedge clk);
        chk("b2b_rd_accept", 64'(cmd_ready), 64'd1);
        chk("b2b_wr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("b2b_rd_we", 64'(dtcm_ram_we), 64'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("b2b_rd_data", 64'(rsp_rdata), 64'hA5A5_A5A5);
        @(posedge clk);
        #1;

        // Byte-mask merge
        issue(1'b0, 14'd7, 32'h1122_3344, 4'hF);
        issue(1'b0, 14'd7, 32'hFFFF_FFFF, 4'h2);
        issue(1'b1, 14'd7, 32'h0, 4'h0);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mask_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("mask_rdata", 64'(rsp_rdata), 64'h1122_FF44);
        drain();

        // Backpressure: third read stalls until the FIFO drains
        issue(1'b0, 14'd20, 32'h2020_0001, 4'hF);
        issue(1'b0, 14'd21, 32'h2121_0002, 4'hF);
        issue(1'b0, 14'd22, 32'h2222_0003, 4'hF);
        cmd_valid = 1'b0;
        drain();
        rsp_ready = 1'b0;
        issue(1'b1, 14'd20, 32'h0, 4'h0);
        issue(1'b1, 14'd21, 32'h0, 4'h0);
        cmd_addr = 14'd22;
        @(negedge clk);
        chk("bp_third_stall_a", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("bp_third_stall_b", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        issue(1'b1, 14'd22, 32'h0, 4'h0);
        cmd_valid = 1'b0;
        drain();

        // Light sleep after 16 idle cycles, then wake on request
        n_idle = 0;
        got_ls = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dtcm_ram_ls) begin
                got_ls = 1'b1;
                break;
            end else if (!rsp_valid) begin
                n_idle++;
            end
        end
        chk("ls_reached", 64'(got_ls), 64'd1);
        chk("ls_idle_cycles", 64'(n_idle), 64'd16);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = 14'd21;
        @(negedge clk);
        chk("sleep_ls_on", 64'(dtcm_ram_ls), 64'd1);
        chk("sleep_ready0", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("wake_ls_off", 64'(dtcm_ram_ls), 64'd0);
        chk("wake_ready0", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("wake_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        drain();

        // Reset with two responses buffered
        rsp_ready = 1'b0;
        issue(1'b1, 14'd20, 32'h0, 4'h0);
        issue(1'b1, 14'd21, 32'h0, 4'h0);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("midrst_no_stale", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        // Pointer wrap: ten reads with rsp_ready toggling every cycle
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, AW'(40 + i), 32'hC0DE_0000 + 32'(i * 7), 4'hF);
        end
        cmd_valid = 1'b0;
        drain();
        pop_base = n_pop;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    issue(1'b1, AW'(40 + i), 32'h0, 4'h0);
                end
                cmd_valid = 1'b0;
                done      = 1'b1;
            end
            begin
                for (int k = 0; k < 400 && !done; k++) begin
                    rsp_ready = ~rsp_ready;
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();
        chk("wrap_rsp_count", 64'(n_pop - pop_base), 64'd10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
